// File: rtl/otter_bus_pkg.sv
// Shared types for the OTTER data-port arbiter: arbiter state, master id,
// access size encodings and the per-master request payload.
package otter_bus_pkg;

    typedef enum logic {ARB, LOCK1} arb_state_t;
    typedef enum logic {ID_M0, ID_M1} mst_id_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] din;
        logic [1:0]  size;
        logic        sign;
    } mem_req_t;

endpackage

// File: rtl/otter_rd_tag_pipe.sv
// Tracks accepted reads through the memory latency so the returning data can
// be flagged valid for the master that issued it.
module otter_rd_tag_pipe
    import otter_bus_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    CLK,
    input  logic    RST_N,
    input  logic    push_i,
    input  mst_id_t id_i,
    output logic    m0_rvalid_o,
    output logic    m1_rvalid_o
);

    // Stage s holds the read issued s cycles ago; stage RD_LAT lines up with MEM_DOUT.
    logic [RD_LAT:1] vld_pipe;
    logic [RD_LAT:1] id_pipe;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe[1] <= push_i;
            id_pipe[1]  <= id_i;
            for (int s = 2; s <= RD_LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                id_pipe[s]  <= id_pipe[s-1];
            end
        end
    end

    assign m0_rvalid_o = vld_pipe[RD_LAT] && (mst_id_t'(id_pipe[RD_LAT]) == ID_M0);
    assign m1_rvalid_o = vld_pipe[RD_LAT] && (mst_id_t'(id_pipe[RD_LAT]) == ID_M1);

endmodule

// File: rtl/otter_mem_arbiter.sv
// Shares the OTTER data-memory port between the CPU (M0) and a DMA/debug
// master (M1): round-robin arbitration, capped M1 lock bursts, read return routing.
module otter_mem_arbiter
    import otter_bus_pkg::*;
#(
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 8
) (
    input  logic        CLK,
    input  logic        RST_N,

    input  logic        M0_REQ,
    input  logic        M0_WE,
    input  logic [31:0] M0_ADDR,
    input  logic [31:0] M0_DIN,
    input  logic [1:0]  M0_SIZE,
    input  logic        M0_SIGN,
    output logic        M0_GNT,
    output logic        M0_RVALID,
    output logic [31:0] M0_DOUT,

    input  logic        M1_REQ,
    input  logic        M1_WE,
    input  logic [31:0] M1_ADDR,
    input  logic [31:0] M1_DIN,
    input  logic [1:0]  M1_SIZE,
    input  logic        M1_SIGN,
    output logic        M1_GNT,
    output logic        M1_RVALID,
    output logic [31:0] M1_DOUT,
    input  logic        M1_LOCK,

    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_DIN,
    output logic        MEM_WE,
    output logic        MEM_RDEN,
    output logic [1:0]  MEM_SIZE,
    output logic        MEM_SIGN,
    input  logic [31:0] MEM_DOUT
);

    localparam logic [7:0] LOCK_CAP = 8'(MAX_LOCK);

    arb_state_t state_q, state_d;
    mst_id_t    ptr_q, ptr_d;
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic       gnt0, gnt1, locked;
    mem_req_t   m0_req, m1_req, sel_req;

    assign m0_req = '{we: M0_WE, addr: M0_ADDR, din: M0_DIN, size: M0_SIZE, sign: M0_SIGN};
    assign m1_req = '{we: M1_WE, addr: M1_ADDR, din: M1_DIN, size: M1_SIZE, sign: M1_SIGN};

    // Dropping M1_LOCK or M1_REQ ends the burst in the same cycle, so that
    // cycle is arbitrated as if already back in ARB.
    assign locked = (state_q == LOCK1) && M1_LOCK && M1_REQ;

    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_cnt_d = lock_cnt_q;
        if (!RST_N) begin
            gnt0 = 1'b0;
        end else if (locked) begin
            if (M0_REQ && (lock_cnt_q == LOCK_CAP)) begin
                gnt0       = 1'b1;
                state_d    = ARB;
                lock_cnt_d = 8'd0;
            end else begin
                gnt1 = 1'b1;
                // Only grants that actually starve M0 count toward the cap.
                if (M0_REQ) lock_cnt_d = lock_cnt_q + 8'd1;
            end
        end else begin
            state_d    = ARB;
            lock_cnt_d = 8'd0;
            if (M0_REQ && (!M1_REQ || ptr_q == ID_M1)) begin
                gnt0 = 1'b1;
            end else if (M1_REQ) begin
                gnt1 = 1'b1;
                if (M1_LOCK) begin
                    state_d    = LOCK1;
                    lock_cnt_d = 8'd1;
                end
            end
        end
        if (gnt0)      ptr_d = ID_M0;
        else if (gnt1) ptr_d = ID_M1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ARB;
            ptr_q      <= ID_M1;
            lock_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    always_comb begin
        sel_req = '0;
        if (gnt0)      sel_req = m0_req;
        else if (gnt1) sel_req = m1_req;
    end

    assign M0_GNT   = gnt0;
    assign M1_GNT   = gnt1;
    assign MEM_ADDR = sel_req.addr;
    assign MEM_DIN  = sel_req.din;
    assign MEM_SIZE = sel_req.size;
    assign MEM_SIGN = sel_req.sign;
    assign MEM_WE   = sel_req.we;
    assign MEM_RDEN = (gnt0 || gnt1) && !sel_req.we;

    otter_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .push_i      (MEM_RDEN),
        .id_i        (gnt1 ? ID_M1 : ID_M0),
        .m0_rvalid_o (M0_RVALID),
        .m1_rvalid_o (M1_RVALID)
    );

    assign M0_DOUT = MEM_DOUT;
    assign M1_DOUT = MEM_DOUT;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed bench for otter_mem_arbiter: one instance at RD_LAT=1 and one at
// RD_LAT=3 share stimulus but have independent resets.
module tb_otter_mem_arbiter;
    import otter_bus_pkg::*;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        rst_n, rst3_n;
    logic        m0_req, m0_we, m0_sign, m1_req, m1_we, m1_sign, m1_lock;
    logic [31:0] m0_addr, m0_din, m1_addr, m1_din, mem_dout;
    logic [1:0]  m0_size, m1_size;

    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we, mem_rden, mem_sign;
    logic [31:0] m0_dout, m1_dout, mem_addr, mem_din;
    logic [1:0]  mem_size;

    logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_mem_we, b_mem_rden, b_mem_sign;
    logic [31:0] b_m0_dout, b_m1_dout, b_mem_addr, b_mem_din;
    logic [1:0]  b_mem_size;

    int n_checks = 0;
    int n_fail   = 0;

    otter_mem_arbiter #(.RD_LAT(1), .MAX_LOCK(8)) dut (
        .CLK(CLK), .RST_N(rst_n),
        .M0_REQ(m0_req), .M0_WE(m0_we), .M0_ADDR(m0_addr), .M0_DIN(m0_din),
        .M0_SIZE(m0_size), .M0_SIGN(m0_sign), .M0_GNT(m0_gnt), .M0_RVALID(m0_rvalid),
        .M0_DOUT(m0_dout),
        .M1_REQ(m1_req), .M1_WE(m1_we), .M1_ADDR(m1_addr), .M1_DIN(m1_din),
        .M1_SIZE(m1_size), .M1_SIGN(m1_sign), .M1_GNT(m1_gnt), .M1_RVALID(m1_rvalid),
        .M1_DOUT(m1_dout), .M1_LOCK(m1_lock),
        .MEM_ADDR(mem_addr), .MEM_DIN(mem_din), .MEM_WE(mem_we), .MEM_RDEN(mem_rden),
        .MEM_SIZE(mem_size), .MEM_SIGN(mem_sign), .MEM_DOUT(mem_dout)
    );

    otter_mem_arbiter #(.RD_LAT(3), .MAX_LOCK(8)) dut3 (
        .CLK(CLK), .RST_N(rst3_n),
        .M0_REQ(m0_req), .M0_WE(m0_we), .M0_ADDR(m0_addr), .M0_DIN(m0_din),
        .M0_SIZE(m0_size), .M0_SIGN(m0_sign), .M0_GNT(b_m0_gnt), .M0_RVALID(b_m0_rvalid),
        .M0_DOUT(b_m0_dout),
        .M1_REQ(m1_req), .M1_WE(m1_we), .M1_ADDR(m1_addr), .M1_DIN(m1_din),
        .M1_SIZE(m1_size), .M1_SIGN(m1_sign), .M1_GNT(b_m1_gnt), .M1_RVALID(b_m1_rvalid),
        .M1_DOUT(b_m1_dout), .M1_LOCK(m1_lock),
        .MEM_ADDR(b_mem_addr), .MEM_DIN(b_mem_din), .MEM_WE(b_mem_we), .MEM_RDEN(b_mem_rden),
        .MEM_SIZE(b_mem_size), .MEM_SIGN(b_mem_sign), .MEM_DOUT(mem_dout)
    );

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_din = '0; m0_size = '0; m0_sign = 0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_din = '0; m1_size = '0; m1_sign = 0;
        m1_lock = 0; mem_dout = '0;
    endtask

    task automatic test_reset();
        rst_n = 0; rst3_n = 0;
        idle_inputs();
        @(negedge CLK);
        m0_req = 1; m1_req = 1; m0_addr = 32'h44; m1_addr = 32'h88;
        #1;
        n_checks++; if (m0_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_m0_gnt: got %0b want 0", m0_gnt); end
        n_checks++; if (m1_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_m1_gnt: got %0b want 0", m1_gnt); end
        n_checks++; if (mem_rden !== 1'b0) begin n_fail++; $display("FAIL rst_rden: got %0b want 0", mem_rden); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
        n_checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid: got %b want 00", {m0_rvalid, m1_rvalid}); end
        @(negedge CLK);
        idle_inputs();
        rst_n = 1; rst3_n = 1;
    endtask

    task automatic test_reset_priority();
        @(negedge CLK);
        m0_req = 1; m0_addr = 32'h0000_1000; m1_req = 1; m1_addr = 32'h0000_2000;
        #1;
        n_checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_fail++; $display("FAIL rp_first_gnt: got %b want 10", {m0_gnt, m1_gnt}); end
        n_checks++; if (mem_addr !== 32'h1000) begin n_fail++; $display("FAIL rp_first_addr: got %h want 1000", mem_addr); end
        n_checks++; if (mem_rden !== 1'b1) begin n_fail++; $display("FAIL rp_first_rden: got %0b want 1", mem_rden); end
        @(negedge CLK);
        m0_req = 0; mem_dout = 32'hAAAA_0001;
        #1;
        n_checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin n_fail++; $display("FAIL rp_second_gnt: got %b want 01", {m0_gnt, m1_gnt}); end
        n_checks++; if (mem_addr !== 32'h2000) begin n_fail++; $display("FAIL rp_second_addr: got %h want 2000", mem_addr); end
        n_checks++; if ({m0_rvalid, m1_rvalid} !== 2'b10) begin n_fail++; $display("FAIL rp_m0_ret: got %b want 10", {m0_rvalid, m1_rvalid}); end
        n_checks++; if (m0_dout !== 32'hAAAA_0001) begin n_fail++; $display("FAIL rp_m0_dout: got %h want aaaa0001", m0_dout); end
        @(negedge CLK);
        m1_req = 0; mem_dout = 32'hBBBB_0002;
        #1;
        n_checks++; if ({m0_rvalid, m1_rvalid} !== 2'b01) begin n_fail++; $display("FAIL rp_m1_ret: got %b want 01", {m0_rvalid, m1_rvalid}); end
        n_checks++; if (m1_dout !== 32'hBBBB_0002) begin n_fail++; $display("FAIL rp_m1_dout: got %h want bbbb0002", m1_dout); end
        @(negedge CLK);
        #1;
        n_checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rp_ret_done: got %b want 00", {m0_rvalid, m1_rvalid}); end
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            m0_req = 1; m1_req = 1; m0_addr = 32'hA0; m1_addr = 32'hB0;
            #1;
            n_checks++;
            if ({m0_gnt, m1_gnt} !== (i[0] ? 2'b01 : 2'b10)) begin
                n_fail++; $display("FAIL rr_cycle%0d: got %b want %b", i, {m0_gnt, m1_gnt}, (i[0] ? 2'b01 : 2'b10));
            end
        end
        @(negedge CLK);
        idle_inputs();
    endtask

    task automatic test_lock_cap();
        // Bit i = 1 means M1 expected in cycle i: one ARB M0 win, 8 locked M1, forced M0, re-lock.
        logic [11:0] exp_m1 = 12'hDFE;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            m0_req = 1; m1_req = 1; m1_lock = 1;
            #1;
            n_checks++;
            if ({m0_gnt, m1_gnt} !== {~exp_m1[i], exp_m1[i]}) begin
                n_fail++; $display("FAIL lock_cycle%0d: got %b want %b", i, {m0_gnt, m1_gnt}, {~exp_m1[i], exp_m1[i]});
            end
        end
        @(negedge CLK);
        idle_inputs();
    endtask

    task automatic test_write();
        @(negedge CLK);
        m0_req = 1; m0_we = 1; m0_addr = 32'h1100_0000; m0_din = 32'hDEAD_BEEF; m0_size = SIZE_WORD;
        #1;
        n_checks++; if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_gnt: got %0b want 1", m0_gnt); end
        n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL wr_we: got %0b want 1", mem_we); end
        n_checks++; if (mem_rden !== 1'b0) begin n_fail++; $display("FAIL wr_rden: got %0b want 0", mem_rden); end
        n_checks++; if (mem_din !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_din: got %h want deadbeef", mem_din); end
        n_checks++; if (mem_addr !== 32'h1100_0000) begin n_fail++; $display("FAIL wr_addr: got %h want 11000000", mem_addr); end
        n_checks++; if (mem_size !== 2'd2) begin n_fail++; $display("FAIL wr_size: got %0d want 2", mem_size); end
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            idle_inputs();
            #1;
            n_checks++;
            if ({m0_rvalid, m1_rvalid} !== 2'b00) begin n_fail++; $display("FAIL wr_no_rvalid%0d: got %b want 00", k, {m0_rvalid, m1_rvalid}); end
        end
    endtask

    task automatic test_lat3_and_reset_mid_read();
        @(negedge CLK);
        m0_req = 1; m0_addr = 32'h40;
        #1;
        n_checks++; if (b_m0_gnt !== 1'b1) begin n_fail++; $display("FAIL l3_gnt: got %0b want 1", b_m0_gnt); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            idle_inputs();
            #1;
            n_checks++;
            if (b_m0_rvalid !== (k == 3)) begin n_fail++; $display("FAIL l3_ret%0d: got %0b want %0b", k, b_m0_rvalid, (k == 3)); end
        end
        @(negedge CLK);
        m1_req = 1; m1_addr = 32'h80;
        #1;
        n_checks++; if (b_m1_gnt !== 1'b1) begin n_fail++; $display("FAIL mr_gnt: got %0b want 1", b_m1_gnt); end
        @(negedge CLK);
        m1_req = 0;
        @(negedge CLK);
        rst3_n = 0; m1_req = 1;
        #1;
        n_checks++; if ({b_m0_gnt, b_m1_gnt} !== 2'b00) begin n_fail++; $display("FAIL mr_rst_gnt: got %b want 00", {b_m0_gnt, b_m1_gnt}); end
        n_checks++; if ({b_mem_we, b_mem_rden} !== 2'b00) begin n_fail++; $display("FAIL mr_rst_we_rden: got %b want 00", {b_mem_we, b_mem_rden}); end
        n_checks++; if (b_mem_addr !== 32'h0) begin n_fail++; $display("FAIL mr_rst_addr: got %h want 0", b_mem_addr); end
        n_checks++; if ({b_m0_rvalid, b_m1_rvalid} !== 2'b00) begin n_fail++; $display("FAIL mr_rst_rvalid: got %b want 00", {b_m0_rvalid, b_m1_rvalid}); end
        @(negedge CLK);
        m1_req = 0;
        #1;
        n_checks++; if (b_m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL mr_rst_hold: got %0b want 0", b_m1_rvalid); end
        @(negedge CLK);
        rst3_n = 1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++; if (b_m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL mr_after%0d: got %0b want 0", k, b_m1_rvalid); end
            @(negedge CLK);
        end
    endtask

    task automatic test_idle();
        test_reset();
        @(negedge CLK);
        idle_inputs();
        #1;
        n_checks++; if ({mem_we, mem_rden} !== 2'b00) begin n_fail++; $display("FAIL idle_we_rden: got %b want 00", {mem_we, mem_rden}); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL idle_addr: got %h want 0", mem_addr); end
        n_checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin n_fail++; $display("FAIL idle_gnt: got %b want 00", {m0_gnt, m1_gnt}); end
        @(negedge CLK);
        m1_lock = 1; m1_addr = 32'h55;
        #1;
        n_checks++; if ({m1_gnt, mem_rden} !== 2'b00) begin n_fail++; $display("FAIL idle_lock_noreq: got %b want 00", {m1_gnt, mem_rden}); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL idle_lock_addr: got %h want 0", mem_addr); end
        // Still in ARB with pointer at M1, so M0 must win this tie.
        @(negedge CLK);
        m0_req = 1; m1_req = 1; m1_lock = 1;
        #1;
        n_checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_fail++; $display("FAIL idle_then_tie: got %b want 10", {m0_gnt, m1_gnt}); end
        @(negedge CLK);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_reset_priority();
        test_round_robin();
        test_lock_cap();
        test_write();
        @(negedge CLK);
        test_lat3_and_reset_mid_read();
        test_idle();
        @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
